// File: rtl/debounce_pkg.sv
// Shared types and defaults for the debounce_edge block: FSM state encoding
// and the default number of confirming samples.
package debounce_pkg;

  localparam int STABLE_CYCLES_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE_LO = 2'd0,
    WAIT_HI = 2'd1,
    IDLE_HI = 2'd2,
    WAIT_LO = 2'd3
  } state_t;

  function automatic logic is_wait(input state_t s);
    return (s == WAIT_HI) || (s == WAIT_LO);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer that brings an asynchronous level into the clk domain.
// The synchronizer clears to 0 on reset.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: nonblocking assignments make q take meta's pre-edge value, giving two real stages.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/debounce_edge.sv
// Debouncer with edge pulses: a change on the synchronized input is accepted only after
// STABLE_CYCLES further enabled samples agree. Glitches fall back without producing a pulse.
module debounce_edge
  import debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = STABLE_CYCLES_DEFAULT,
  parameter int CNT_W         = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  input  logic en,
  output logic q,
  output logic qbar,
  output logic rise,
  output logic fall,
  output logic busy
);

  localparam logic [CNT_W-1:0] STABLE_CNT = CNT_W'(STABLE_CYCLES);

  logic             d_s;
  state_t           state;
  logic [CNT_W-1:0] cnt;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (d),
    .q   (d_s)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE_LO;
      cnt   <= '0;
      q     <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (en) begin
        case (state)
          IDLE_LO: if (d_s) begin
            state <= WAIT_HI;
            cnt   <= CNT_W'(1);
          end
          WAIT_HI: if (!d_s) begin
            state <= IDLE_LO;
            cnt   <= '0;
          end else if (cnt == STABLE_CNT) begin
            state <= IDLE_HI;
            q     <= 1'b1;
            rise  <= 1'b1;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
          IDLE_HI: if (!d_s) begin
            state <= WAIT_LO;
            cnt   <= CNT_W'(1);
          end
          WAIT_LO: if (d_s) begin
            state <= IDLE_HI;
            cnt   <= '0;
          end else if (cnt == STABLE_CNT) begin
            state <= IDLE_LO;
            q     <= 1'b0;
            fall  <= 1'b1;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
          default: begin
            state <= IDLE_LO;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

  // q is cleared asynchronously, so qbar is already 1 while reset is held.
  assign qbar = ~q;
  assign busy = is_wait(state);

endmodule

// File: tb/tb_debounce_edge.sv
// Self-checking bench for debounce_edge: constant vector table, directed corner sequences,
// and randomized traffic compared against a run-length reference model.
module tb_debounce_edge;

  localparam int S = 4;

  logic clk = 1'b0;
  logic rst, d, en;
  logic q, qbar, rise, fall, busy;

  debounce_edge #(.STABLE_CYCLES(S), .CNT_W(8)) dut (
    .clk  (clk),
    .rst  (rst),
    .d    (d),
    .en   (en),
    .q    (q),
    .qbar (qbar),
    .rise (rise),
    .fall (fall),
    .busy (busy)
  );

  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: raw d reaches the decision logic two edges later. A change is accepted
  // once S+1 consecutive enabled samples disagree with the current level.
  logic m_s1, m_s2, m_q, m_rise, m_fall;
  int   m_run;

  task automatic model_reset();
    m_s1 = 1'b0; m_s2 = 1'b0; m_q = 1'b0;
    m_rise = 1'b0; m_fall = 1'b0; m_run = 0;
  endtask

  task automatic model_edge();
    logic ds;
    if (rst) begin
      model_reset();
    end else begin
      ds = m_s2;
      m_s2 = m_s1;
      m_s1 = d;
      m_rise = 1'b0;
      m_fall = 1'b0;
      if (en) begin
        if (ds != m_q) begin
          m_run++;
          if (m_run == S + 1) begin
            m_q = ds;
            m_rise = ds;
            m_fall = !ds;
            m_run = 0;
          end
        end else begin
          m_run = 0;
        end
      end
    end
  endtask

  // One clock edge: update the model at the edge, compare on the following falling edge.
  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check(tag, {3'b0, q, qbar, rise, fall, busy},
          {3'b0, m_q, !m_q, m_rise, m_fall, (m_run > 0)});
  endtask

  task automatic drive(input logic dv, input logic ev, input logic rv);
    d = dv; en = ev; rst = rv;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b1, 1'b1);
    tick("reset");
    tick("reset");
    drive(1'b0, 1'b1, 1'b0);
  endtask

  typedef struct {
    logic d;
    logic en;
    logic exp_q;
    logic exp_rise;
    logic exp_fall;
    logic exp_busy;
  } vec_t;

  vec_t tbl [16];

  initial begin
    logic rise_seen, busy_seen;

    // Clean rise then clean fall at STABLE_CYCLES=4; row i is the state after edge i.
    tbl = '{
      '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0},
      '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0},
      '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1},
      '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1},
      '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1},
      '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1},
      '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0},
      '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0},
      '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0},
      '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0},
      '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1},
      '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1},
      '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1},
      '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1},
      '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0},
      '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}
    };

    model_reset();
    drive(1'b0, 1'b1, 1'b0);
    @(negedge clk);

    // Reset held with d=1 and clock running: outputs pinned at their reset values.
    drive(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick("rst_model");
      check("rst_hold", {3'b0, q, qbar, rise, fall, busy}, 8'b0000_1000);
    end
    drive(1'b0, 1'b1, 1'b0);
    tick("rst_release");

    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].d, tbl[i].en, 1'b0);
      tick("tbl_model");
      check($sformatf("vec%0d", i), {4'b0, q, rise, fall, busy},
            {4'b0, tbl[i].exp_q, tbl[i].exp_rise, tbl[i].exp_fall, tbl[i].exp_busy});
    end

    // Asynchronous reset: from q=1, asserting rst between edges clears q immediately.
    drive(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) tick("pre_async");
    check("pre_async_q", 8'(q), 8'd1);
    rst = 1'b1;
    #1;
    check("async_rst", {6'b0, q, qbar}, 8'b0000_0001);
    tick("async_hold");
    drive(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) tick("settle");

    // Glitch: d high for edges 0..2 only; the candidate rise must be abandoned.
    rise_seen = 1'b0;
    busy_seen = 1'b0;
    for (int e = 0; e < 9; e++) begin
      drive((e <= 2), 1'b1, 1'b0);
      tick("glitch_model");
      rise_seen |= rise;
      busy_seen |= busy;
    end
    check("glitch_busy_seen", 8'(busy_seen), 8'd1);
    check("glitch_no_rise", 8'(rise_seen), 8'd0);
    check("glitch_end", {6'b0, q, busy}, 8'd0);

    // Reset pulse between edges 4 and 5 of a confirmation; restart from a cleared synchronizer.
    rise_seen = 1'b0;
    for (int e = 0; e < 5; e++) begin
      drive(1'b1, 1'b1, 1'b0);
      tick("midrst_model");
      rise_seen |= rise;
    end
    check("midrst_busy_before", 8'(busy), 8'd1);
    rst = 1'b1;
    #2;
    model_reset();
    check("midrst_abort", {5'b0, q, rise, busy}, 8'd0);
    rst = 1'b0;
    for (int e = 0; e < 8; e++) begin
      tick("midrst_after");
      if (e < 6) rise_seen |= rise;
      if (e == 5 || e == 6 || e == 7)
        check($sformatf("midrst_e%0d", e), {6'b0, q, rise}, {6'b0, 1'(e >= 6), 1'(e == 6)});
    end
    check("midrst_no_early_rise", 8'(rise_seen), 8'd0);

    // Enable stall: en low on edges 3..5 delays the rise by exactly three edges (to edge 9).
    do_reset();
    for (int e = 0; e < 11; e++) begin
      drive(1'b1, !(e >= 3 && e <= 5), 1'b0);
      tick("stall_model");
      if (e == 4) check("stall_busy", 8'(busy), 8'd1);
      if (e >= 6) check($sformatf("stall_e%0d", e), {6'b0, q, rise},
                        {6'b0, 1'(e >= 9), 1'(e == 9)});
    end

    // Boundary: d high for L edges. L=4 reverses d_s exactly when the count completes
    // (rejected); L=5 keeps d_s high through that edge (accepted).
    for (int l = 4; l <= 5; l++) begin
      do_reset();
      for (int e = 0; e < 10; e++) begin
        drive((e < l), 1'b1, 1'b0);
        tick("bound_model");
        if (e == 6) check($sformatf("bound_L%0d", l), {5'b0, q, rise, busy},
                          {5'b0, 1'(l == 5), 1'(l == 5), 1'b0});
      end
    end

    // Randomized traffic against the reference model.
    do_reset();
    begin
      logic dv = 1'b0;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(7) == 0) dv = !dv;
        drive(dv, ($urandom_range(9) != 0), ($urandom_range(249) == 0));
        tick("rand_model");
        if (rise || fall) check("rand_excl", 8'(rise & fall), 8'd0);
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
